// File: rtl/pacman_sprite_reader.sv
// pacman_sprite_reader
// Read-side client of the twelve 16x16 pacman sprite ROMs. Turns the scan
// position into a ROM address, runs the mouth-animation sequencer, and
// produces a pixel-on flag aligned to the ROM's one-clock read latency.
//
// There is no valid/ready handshake on this block: draw_x/draw_y are taken
// every cycle and pix_on for the position presented in cycle N is valid in
// cycle N+1. Sprite position, direction and animation state only change on
// frame_tick, so a frame is never drawn with mixed state.
module pacman_sprite_reader #(
  parameter int          ANIM_DIV = 4,
  parameter logic [9:0]  PAC_X0   = 10'd312,
  parameter logic [9:0]  PAC_Y0   = 10'd232
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [1:0]  dir,
  input  logic        moving,
  input  logic        freeze,
  input  logic [9:0]  pac_x,
  input  logic [9:0]  pac_y,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  output logic [7:0]  rom_addr,
  input  logic [11:0] rom_q,
  output logic        pix_on,
  output logic [1:0]  frame_num
);

  localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

  // Per-frame latched sprite state
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [1:0] dir_l;

  // Animation sequencer state
  logic [7:0] div_cnt;
  logic [1:0] phase;
  logic [7:0] div_next;
  logic [1:0] phase_next;

  // Hit test and address generation
  logic [10:0] dx_wide;
  logic [10:0] dy_wide;
  logic        hit;
  logic [9:0]  dx;
  logic [9:0]  dy;

  // Selection pipeline aligned to ROM latency
  logic       hit_d;
  logic [3:0] sel_d;
  logic [3:0] sel_now;

  // Mouth sequence 1,2,3,2 indexed by phase
  function automatic logic [1:0] phase_to_frame(input logic [1:0] p);
    case (p)
      2'd0:    phase_to_frame = 2'd1;
      2'd1:    phase_to_frame = 2'd2;
      2'd2:    phase_to_frame = 2'd3;
      default: phase_to_frame = 2'd2;
    endcase
  endfunction

  // Latch sprite position and facing once per frame
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_x <= PAC_X0;
      pos_y <= PAC_Y0;
      dir_l <= 2'b00;
    end else if (frame_tick) begin
      pos_x <= pac_x;
      pos_y <= pac_y;
      dir_l <= dir;
    end
  end

  // Next animation divider/phase: only a moving, unfrozen frame advances
  always_comb begin
    div_next   = div_cnt;
    phase_next = phase;
    if (frame_tick && moving && !freeze) begin
      if (div_cnt == DIV_LAST) begin
        div_next   = 8'd0;
        phase_next = phase + 2'd1;
      end else begin
        div_next = div_cnt + 8'd1;
      end
    end
  end

  // Animation state and registered frame number
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= 8'd0;
      phase     <= 2'd0;
      frame_num <= 2'd1;
    end else begin
      div_cnt   <= div_next;
      phase     <= phase_next;
      frame_num <= phase_to_frame(phase_next);
    end
  end

  // Hit test in 11 bits so a sprite near the right/bottom edge cannot wrap
  always_comb begin
    dx_wide  = {1'b0, pos_x} + 11'd16;
    dy_wide  = {1'b0, pos_y} + 11'd16;
    hit      = ({1'b0, draw_x} >= {1'b0, pos_x}) && ({1'b0, draw_x} < dx_wide) &&
               ({1'b0, draw_y} >= {1'b0, pos_y}) && ({1'b0, draw_y} < dy_wide);
    dx       = draw_x - pos_x;
    dy       = draw_y - pos_y;
    rom_addr = hit ? {dy[3:0], dx[3:0]} : 8'd0;
  end

  // ROM index for the current facing and mouth frame (0..11)
  always_comb begin
    sel_now = ({2'b00, dir_l} * 4'd3) + {2'b00, frame_num} - 4'd1;
  end

  // One-stage pipeline matching the ROM read latency
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_d <= 1'b0;
      sel_d <= 4'd0;
    end else begin
      hit_d <= hit;
      sel_d <= sel_now;
    end
  end

  // Pick the selected ROM bit for the delayed hit
  always_comb begin
    pix_on = hit_d & rom_q[sel_d];
  end

endmodule

// File: tb/tb_pacman_sprite_reader.sv
// tb_pacman_sprite_reader
// Drives scan positions and frame events, models the twelve sprite ROMs,
// and checks rom_addr, pix_on and frame_num against a reference model.
module tb_pacman_sprite_reader;

  localparam int ANIM_DIV = 4;

  // Clock / reset
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic        frame_tick = 1'b0;
  logic [1:0]  dir = 2'b00;
  logic        moving = 1'b0;
  logic        freeze = 1'b0;
  logic [9:0]  pac_x = 10'd0;
  logic [9:0]  pac_y = 10'd0;
  logic [9:0]  draw_x = 10'd0;
  logic [9:0]  draw_y = 10'd0;
  logic [7:0]  rom_addr;
  logic [11:0] rom_q = 12'd0;
  logic        pix_on;
  logic [1:0]  frame_num;

  pacman_sprite_reader #(
    .ANIM_DIV(ANIM_DIV),
    .PAC_X0(10'd312),
    .PAC_Y0(10'd232)
  ) dut (
    .clock(clock),
    .reset(reset),
    .frame_tick(frame_tick),
    .dir(dir),
    .moving(moving),
    .freeze(freeze),
    .pac_x(pac_x),
    .pac_y(pac_y),
    .draw_x(draw_x),
    .draw_y(draw_y),
    .rom_addr(rom_addr),
    .rom_q(rom_q),
    .pix_on(pix_on),
    .frame_num(frame_num)
  );

  // Sprite ROM model: random contents, registered read of the DUT address
  logic [255:0] rom_mem [12];
  logic         rom_force = 1'b0;

  always @(posedge clock) begin
    logic [11:0] t;
    for (int k = 0; k < 12; k++) t[k] = rom_mem[k][rom_addr];
    rom_q <= rom_force ? 12'hFFF : t;
  end

  // Reference model state
  int m_px, m_py, m_dir, m_div, m_phase;
  int frame_seq [4] = '{1, 2, 3, 2};

  // Scoreboard
  logic [0:0] exp_q [$];
  logic [1:0] exp_f_q [$];
  int n_checks = 0;
  int n_errors = 0;

  // Monitor: pops one expectation per clock once the driver has issued it
  always @(posedge clock) begin
    #2;
    if (exp_q.size() > 0) begin
      logic [0:0] ep;
      logic [1:0] ef;
      ep = exp_q.pop_front();
      ef = exp_f_q.pop_front();
      n_checks++;
      if (pix_on !== ep) begin
        n_errors++;
        $display("FAIL pix_on t=%0t got=%b exp=%b", $time, pix_on, ep);
      end
      n_checks++;
      if (frame_num !== ef) begin
        n_errors++;
        $display("FAIL frame_num t=%0t got=%0d exp=%0d", $time, frame_num, ef);
      end
    end
  end

  // Driver: one clock of stimulus, model prediction and state update
  task automatic step(input logic rst, input logic tick, input logic mv, input logic frz,
                      input logic [1:0] d, input int px, input int py,
                      input int dxp, input int dyp);
    int  ex_addr;
    bit  h;
    int  sel;
    logic [0:0] ep;
    @(negedge clock);
    reset = rst; frame_tick = tick; moving = mv; freeze = frz; dir = d;
    pac_x = 10'(px); pac_y = 10'(py); draw_x = 10'(dxp); draw_y = 10'(dyp);
    #1;
    h = (dxp >= m_px) && (dxp < m_px + 16) && (dyp >= m_py) && (dyp < m_py + 16);
    ex_addr = h ? ((dyp - m_py) * 16 + (dxp - m_px)) : 0;
    n_checks++;
    if (rom_addr !== 8'(ex_addr)) begin
      n_errors++;
      $display("FAIL rom_addr draw=(%0d,%0d) pos=(%0d,%0d) got=%0d exp=%0d",
               dxp, dyp, m_px, m_py, rom_addr, ex_addr);
    end
    sel = m_dir * 3 + frame_seq[m_phase] - 1;
    if (rst) ep = 1'b0;
    else     ep = h && (rom_force || rom_mem[sel][ex_addr]);
    exp_q.push_back(ep);
    if (rst) begin
      m_px = 312; m_py = 232; m_dir = 0; m_div = 0; m_phase = 0;
    end else if (tick) begin
      m_px = px; m_py = py; m_dir = int'(d);
      if (mv && !frz) begin
        if (m_div == ANIM_DIV - 1) begin
          m_div = 0;
          m_phase = (m_phase + 1) % 4;
        end else begin
          m_div = m_div + 1;
        end
      end
    end
    exp_f_q.push_back(2'(frame_seq[m_phase]));
  endtask

  // Draw-only cycle with current latched state
  task automatic draw(input int dxp, input int dyp);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'(m_dir), m_px, m_py, dxp, dyp);
  endtask

  initial begin
    for (int k = 0; k < 12; k++)
      for (int a = 0; a < 256; a += 32) rom_mem[k][a +: 32] = $urandom;
    m_px = 312; m_py = 232; m_dir = 0; m_div = 0; m_phase = 0;

    // Reset, then latch position (100,50)
    step(1, 0, 0, 0, 0, 0, 0, 312, 232);
    step(1, 0, 0, 0, 0, 0, 0, 312, 232);
    draw(312, 232);
    step(0, 1, 0, 0, 0, 100, 50, 0, 0);
    draw(100, 50);
    draw(115, 65);
    draw(107, 58);
    rom_force = 1'b1;
    draw(116, 65);
    draw(99, 50);
    draw(100, 66);
    draw(100, 50);
    draw(115, 65);
    rom_force = 1'b0;

    // Animation: 16 moving ticks, then 8 frozen, then 4 non-moving
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 0, 0, 100, 50, 100 + i, 50 + i);
      draw(100 + (15 - i), 50 + i);
    end
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 0, 100, 50, 105, 55);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 100, 50, 106, 56);

    // Walk to frame 3, then dir change without tick must not take effect
    while (m_phase != 2) step(0, 1, 1, 0, 0, 100, 50, 103, 53);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 2'b10, 200, 200, 100 + $urandom_range(0, 15), 50 + $urandom_range(0, 15));
    end
    step(0, 1, 0, 0, 2'b10, 100, 50, 101, 51);
    for (int i = 0; i < 12; i++) draw(100 + $urandom_range(0, 15), 50 + $urandom_range(0, 15));

    // Right-edge sprite must not wrap
    step(0, 1, 0, 0, 2'b01, 1020, 100, 0, 0);
    rom_force = 1'b1;
    draw(2, 100);
    draw(0, 105);
    draw(1023, 100);
    draw(1020, 115);
    rom_force = 1'b0;

    // Reset wins over a simultaneous frame_tick
    step(0, 1, 1, 0, 2'b11, 40, 40, 0, 0);
    step(1, 1, 1, 0, 2'b11, 500, 40, 500, 40);
    rom_force = 1'b1;
    draw(500, 40);
    draw(312, 232);
    draw(327, 247);
    rom_force = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic rst, tick, mv, frz;
      int px, py, dxp, dyp;
      rst  = ($urandom_range(0, 63) == 0);
      tick = ($urandom_range(0, 7) == 0);
      mv   = ($urandom_range(0, 3) != 0);
      frz  = ($urandom_range(0, 5) == 0);
      px   = (i % 50 == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
      py   = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) begin
        dxp = m_px + $urandom_range(0, 20) - 2;
        dyp = m_py + $urandom_range(0, 20) - 2;
        if (dxp < 0) dxp = 0;
        if (dyp < 0) dyp = 0;
        if (dxp > 1023) dxp = 1023;
        if (dyp > 1023) dyp = 1023;
      end else begin
        dxp = $urandom_range(0, 1023);
        dyp = $urandom_range(0, 1023);
      end
      step(rst, tick, mv, frz, 2'($urandom_range(0, 3)), px, py, dxp, dyp);
    end

    draw(0, 0);
    @(posedge clock);
    #4;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pacman_sprite_reader.md
Name: pacman_sprite_reader

Overview:
- Read-side client of the 16x16 pacman sprite ROMs (12 ROMs: 4 directions x 3 mouth frames; 8-bit address, 1-bit q, 1-clock registered read).
- Converts the VGA scan position into a ROM address, selects which ROM output to use, runs the mouth-animation sequencer, and emits a pixel-on flag aligned to ROM read latency.
- Sits between the VGA controller / pacman motion logic and the colour mapper.

Parameters:
- ANIM_DIV, 4, frame_ticks per animation phase step (1..255)
- PAC_X0, 10'd312, reset value of the latched sprite X
- PAC_Y0, 10'd232, reset value of the latched sprite Y

Ports:
- clock  in  1  system clock, also clocks the sprite ROMs
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame (vsync edge)
- dir  in  2  requested facing: 00 right, 01 left, 10 up, 11 down
- moving  in  1  pacman moved this frame; animation advances only when 1
- freeze  in  1  freeze power-up active; holds animation
- pac_x  in  10  sprite top-left X from motion logic
- pac_y  in  10  sprite top-left Y from motion logic
- draw_x  in  10  current scan X
- draw_y  in  10  current scan Y
- rom_addr  out  8  address to all 12 pacman ROMs
- rom_q  in  12  concatenated ROM q bits; index = dir*3 + (frame-1)
- pix_on  out  1  sprite pixel opaque at the draw position presented one clock earlier
- frame_num  out  2  current mouth frame 1..3 (debug/score logic)

Behaviour:
- Interface: one clock domain. Reset is synchronous and active-high. Reset has priority over every other input, including frame_tick in the same cycle.
- Latched state, updated only on frame_tick so a frame never tears:
  - pos_x/pos_y <= pac_x/pac_y
  - dir_l <= dir
  - Reset values: PAC_X0, PAC_Y0, 2'b00.
- Hit test (combinational, 11-bit unsigned, no wrap):
  - hit = (draw_x >= pos_x) && (draw_x < pos_x+16) && (draw_y >= pos_y) && (draw_y < pos_y+16).
  - A pos_x near 1023 must not wrap to produce a hit at low draw_x.
- Address (combinational): rom_addr = hit ? {dy[3:0], dx[3:0]} : 8'd0, where dx = draw_x-pos_x and dy = draw_y-pos_y.
  - Row-major order, so address 0 is top-left.
- Animation sequencer:
  - div counter (8-bit) and phase (2-bit); both reset to 0.
  - On frame_tick with moving=1 and freeze=0: div++. When div reaches ANIM_DIV-1, div <= 0 and phase <= phase+1 (mod 4).
  - freeze=1 or moving=0 on frame_tick: div and phase hold.
  - Phase-to-frame map: 0->1, 1->2, 2->3, 3->2, giving the sequence 1,2,3,2,1...
  - frame_num is a registered output driven from this map. Reset value 1.
- Selection pipeline (1 stage, matches the ROM's 1-clock latency):
  - hit_d <= hit
  - sel_d <= dir_l*3 + frame_num-1 (range 0..11)
  - pix_on = hit_d & rom_q[sel_d]
  - hit_d and sel_d reset to 0, so pix_on = 0 out of reset.
- Latency: draw_x/draw_y presented in cycle N; pix_on valid in cycle N+1.
- Direction or frame change mid-frame:
  - Occurs only at frame_tick. sel_d follows one cycle later.
  - The pixel whose address was issued in the frame_tick cycle uses the pre-tick selection.
- Reset mid-frame: all latched state returns to reset values on the next edge. pix_on = 0 the cycle after reset is sampled.
- ANIM_DIV=1: phase advances on every qualifying frame_tick.

Test Plan:
- Reset, pac_x=100, pac_y=50, frame_tick, then draw (100,50) -> rom_addr=0x00 same cycle; next cycle pix_on=rom_q[0], frame_num=1.
- Draw (115,65) with pos (100,50) -> rom_addr=0xFF. Draw (116,65) and (99,50) -> rom_addr=0, pix_on=0 a cycle later regardless of rom_q=12'hFFF.
- ANIM_DIV=4, moving=1, 16 frame_ticks -> frame_num after each group of 4 ticks: 2,3,2,1. With freeze=1 for 8 more ticks, frame_num holds.
- dir=10 applied mid-frame without frame_tick -> selection unchanged. After frame_tick with frame 3 -> pix_on follows rom_q[8].
- pos_x=1020, draw_x=2 -> no hit (no wrap), pix_on=0.
- reset asserted together with frame_tick and pac_x=500 -> pos_x=PAC_X0 (312), phase=0, frame_num=1, pix_on=0.
